// File: rtl/mk_top.sv
// mk_top: multicycle RV32I core behind a request/response memory port.
//
// Ports
//   CLK               single clock, all state updates on its rising edge
//   RST               synchronous, active-high reset
//   EN_obtain_rq_get  environment dequeues the presented request this cycle
//   obtain_rq_get     request {addr[64:33], iswrite[32], data[31:0]}
//   RDY_obtain_rq_get a valid request is presented
//   send_rs_put       response data (read word; ignored for writes)
//   EN_send_rs_put    environment delivers a response this cycle
//   RDY_send_rs_put   a response can be accepted this cycle
//
// Sequence per instruction: FETCH_RQ -> (FETCH_RS) -> EXEC, then for LW/SW
// MEM_RQ -> (MEM_RS). A response arriving together with the dequeue skips
// the *_RS wait state.
module mk_top (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN_obtain_rq_get,
    output logic [64:0] obtain_rq_get,
    output logic        RDY_obtain_rq_get,
    input  logic [31:0] send_rs_put,
    input  logic        EN_send_rs_put,
    output logic        RDY_send_rs_put
);

    localparam logic [2:0] FETCH_RQ = 3'd0;
    localparam logic [2:0] FETCH_RS = 3'd1;
    localparam logic [2:0] EXEC     = 3'd2;
    localparam logic [2:0] MEM_RQ   = 3'd3;
    localparam logic [2:0] MEM_RS   = 3'd4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rf [32];
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u   = {ir[31:12], 12'h000};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // ALU shared by OP and OP-IMM. bit30 selects SUB only for register ADD,
    // and SRA/SRAI for the right shifts.
    logic [31:0] alu_b;
    logic        alu_alt;
    logic [31:0] alu_out;

    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_alt = ir[30] && ((opcode == OPC_OP) || (funct3 == 3'b101));

    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    always_comb begin
        alu_out = 32'h0;
        case (funct3)
            3'b000: alu_out = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'h0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                      : (rs1_val >> alu_b[4:0]);
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Effect of the latched instruction, applied in EXEC
    logic        wb_en;
    logic [31:0] wb_val;
    logic [31:0] next_pc;
    logic        is_mem;
    logic        is_store;
    logic [31:0] eff_addr;

    always_comb begin
        wb_en    = 1'b0;
        wb_val   = 32'h0;
        next_pc  = pc + 32'd4;
        is_mem   = 1'b0;
        is_store = 1'b0;
        eff_addr = rs1_val + imm_i;
        case (opcode)
            OPC_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OPC_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc + imm_u;
            end
            OPC_JAL: begin
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'h1;
            end
            OPC_BRANCH: begin
                if (br_taken) next_pc = pc + imm_b;
            end
            OPC_LOAD: begin
                is_mem = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                is_mem   = (funct3 == 3'b010);
                is_store = (funct3 == 3'b010);
                eff_addr = rs1_val + imm_s;
            end
            OPC_OPIMM, OPC_OP: begin
                wb_en  = 1'b1;
                wb_val = alu_out;
            end
            default: ;
        endcase
    end

    // Port outputs are forced quiet while reset is held.
    always_comb begin
        obtain_rq_get     = 65'h0;
        RDY_obtain_rq_get = 1'b0;
        RDY_send_rs_put   = 1'b0;
        if (!RST) begin
            case (state)
                FETCH_RQ: begin
                    RDY_obtain_rq_get = 1'b1;
                    RDY_send_rs_put   = 1'b1;
                    obtain_rq_get     = {pc, 1'b0, 32'h0};
                end
                FETCH_RS: RDY_send_rs_put = 1'b1;
                MEM_RQ: begin
                    RDY_obtain_rq_get = 1'b1;
                    RDY_send_rs_put   = 1'b1;
                    obtain_rq_get     = {mem_addr, mem_write, mem_wdata};
                end
                MEM_RS: RDY_send_rs_put = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is assigned only with <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH_RQ;
            pc        <= 32'h0;
            ir        <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_write <= 1'b0;
            // NOTE: the register file is cleared on reset because software
            // observes x1..x31 as zero afterwards; this rules out a RAM macro.
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            case (state)
                FETCH_RQ: begin
                    if (EN_obtain_rq_get) begin
                        if (EN_send_rs_put) begin
                            ir    <= send_rs_put;
                            state <= EXEC;
                        end else begin
                            state <= FETCH_RS;
                        end
                    end
                end
                FETCH_RS: begin
                    if (EN_send_rs_put) begin
                        ir    <= send_rs_put;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    pc        <= next_pc;
                    mem_addr  <= eff_addr;
                    mem_write <= is_store;
                    mem_wdata <= is_store ? rs2_val : 32'h0;
                    if (wb_en && (rd != 5'd0)) rf[rd] <= wb_val;
                    state <= is_mem ? MEM_RQ : FETCH_RQ;
                end
                MEM_RQ: begin
                    if (EN_obtain_rq_get) begin
                        if (EN_send_rs_put) begin
                            if (!mem_write && (rd != 5'd0)) rf[rd] <= send_rs_put;
                            state <= FETCH_RQ;
                        end else begin
                            state <= MEM_RS;
                        end
                    end
                end
                MEM_RS: begin
                    if (EN_send_rs_put) begin
                        if (!mem_write && (rd != 5'd0)) rf[rd] <= send_rs_put;
                        state <= FETCH_RQ;
                    end
                end
                default: state <= FETCH_RQ;
            endcase
        end
    end

endmodule

// File: tb/tb_mk_top.sv
// tb_mk_top: drives mk_top as a memory environment and compares every
// dequeued request against an instruction-level RV32I model that shares the
// bench memory. Directed programs pin the model with literal results.
module tb_mk_top;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN_obtain_rq_get;
    logic [64:0] obtain_rq_get;
    logic        RDY_obtain_rq_get;
    logic [31:0] send_rs_put;
    logic        EN_send_rs_put;
    logic        RDY_send_rs_put;

    always #5 CLK = ~CLK;

    mk_top dut (
        .CLK              (CLK),
        .RST              (RST),
        .EN_obtain_rq_get (EN_obtain_rq_get),
        .obtain_rq_get    (obtain_rq_get),
        .RDY_obtain_rq_get(RDY_obtain_rq_get),
        .send_rs_put      (send_rs_put),
        .EN_send_rs_put   (EN_send_rs_put),
        .RDY_send_rs_put  (RDY_send_rs_put)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shared memory, word-indexed by addr[11:2] (higher addresses alias)
    logic [31:0] mem [1024];

    // Instruction-level model
    logic [31:0] m_pc;
    logic [31:0] xr [32];
    bit          m_mem_phase;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    bit          m_wr;
    logic [4:0]  m_rd;

    // What the DUT was observed doing
    logic [31:0] fetch_log [$];
    logic [31:0] dut_wr_addr;
    logic [31:0] dut_wr_data;

    // Environment behaviour knobs
    int take_pct, same_pct, dly_min, dly_max, hold_cfg;

    // Environment state
    bit          pending;
    int          delay_left;
    int          hold_left;
    logic [31:0] resp;
    bit          prev_held;
    logic [64:0] prev_req;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input bit alt);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_exec(input logic [31:0] ins);
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, ii, si, bi, ui, ji, res, nxt;
        bit          wb, taken;
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        a   = xr[rs1];
        b   = xr[rs2];
        ii  = 32'($signed(ins) >>> 20);
        si  = (ii & ~32'h1f) | 32'(rd);
        bi  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ui  = ins & 32'hffff_f000;
        ji  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        nxt = m_pc + 4;
        res = 0;
        wb  = 0;
        taken = 0;
        case (op)
            7'h37: begin res = ui; wb = 1; end
            7'h17: begin res = m_pc + ui; wb = 1; end
            7'h6f: begin res = m_pc + 4; wb = 1; nxt = m_pc + ji; end
            7'h67: begin res = m_pc + 4; wb = 1; nxt = (a + ii) & ~32'h1; end
            7'h63: begin
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = (a >= b);
                    default: taken = 0;
                endcase
                if (taken) nxt = m_pc + bi;
            end
            7'h03: if (f3 == 3'd2) begin
                m_mem_phase = 1; m_addr = a + ii; m_wr = 0; m_data = 0; m_rd = rd;
            end
            7'h23: if (f3 == 3'd2) begin
                m_mem_phase = 1; m_addr = a + si; m_wr = 1; m_data = b; m_rd = rd;
            end
            7'h13: begin res = alu(f3, a, ii, (f3 == 3'd5) && ins[30]); wb = 1; end
            7'h33: begin res = alu(f3, a, b, ins[30]); wb = 1; end
            default: ;
        endcase
        if (wb && rd != 0) xr[rd] = res;
        m_pc = nxt;
    endtask

    function automatic logic [64:0] model_req();
        return m_mem_phase ? {m_addr, m_wr, m_data} : {m_pc, 1'b0, 32'h0};
    endfunction

    // Completes the model's current transaction and returns the response word
    task automatic model_accept(output logic [31:0] r);
        if (!m_mem_phase) begin
            r = mem[m_pc[11:2]];
            model_exec(r);
        end else begin
            if (m_wr) begin
                mem[m_addr[11:2]] = m_data;
                r = $urandom;
            end else begin
                r = mem[m_addr[11:2]];
                if (m_rd != 0) xr[m_rd] = r;
            end
            m_mem_phase = 0;
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) xr[i] = 0;
        m_mem_phase = 0;
        pending = 0;
        prev_held = 0;
        hold_left = hold_cfg;
    endtask

    // One environment cycle; entered and left 1 time unit after a rising edge
    task automatic cycle(output bit took);
        EN_obtain_rq_get = 0;
        EN_send_rs_put   = 0;
        took = 0;
        if (pending) begin
            check("rs_wait_rdy", {RDY_obtain_rq_get, RDY_send_rs_put}, 2'b01);
            if (delay_left == 0) begin
                EN_send_rs_put = 1;
                send_rs_put    = resp;
                pending        = 0;
            end else begin
                delay_left--;
            end
        end else if (RDY_obtain_rq_get) begin
            if (prev_held) check("hold_stable", obtain_rq_get, prev_req);
            check("rq_rdy_send", RDY_send_rs_put, 1);
            if (hold_left > 0 || $urandom_range(99) >= take_pct) begin
                if (hold_left > 0) hold_left--;
                prev_held = 1;
                prev_req  = obtain_rq_get;
            end else begin
                check("request", obtain_rq_get, model_req());
                if (!m_mem_phase) fetch_log.push_back(obtain_rq_get[64:33]);
                if (obtain_rq_get[32]) begin
                    dut_wr_addr = obtain_rq_get[64:33];
                    dut_wr_data = obtain_rq_get[31:0];
                end
                model_accept(resp);
                EN_obtain_rq_get = 1;
                took      = 1;
                prev_held = 0;
                hold_left = hold_cfg;
                if ($urandom_range(99) < same_pct) begin
                    EN_send_rs_put = 1;
                    send_rs_put    = resp;
                end else begin
                    pending    = 1;
                    delay_left = $urandom_range(dly_max, dly_min);
                end
            end
        end else begin
            check("exec_idle", {RDY_obtain_rq_get, RDY_send_rs_put}, 2'b00);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        int done = 0;
        int cyc  = 0;
        bit t;
        while (done < n && cyc < n * 40) begin
            cycle(t);
            if (t) done++;
            cyc++;
        end
        check("run_budget", done >= n, 1);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1;
        EN_obtain_rq_get = 0;
        EN_send_rs_put   = 0;
        @(posedge CLK);
        #1;
        check("reset_outputs", {RDY_obtain_rq_get, RDY_send_rs_put, obtain_rq_get}, 0);
        @(posedge CLK);
        #1;
        RST = 0;
        model_reset();
        fetch_log.delete();
        dut_wr_addr = 32'hdead_beef;
        dut_wr_data = 32'hdead_beef;
        #1;
        check("first_fetch", {RDY_obtain_rq_get, obtain_rq_get[64:32]}, {1'b1, 33'h0});
    endtask

    // Encoders for directed programs
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] rand_ins();
        int cls = $urandom_range(9);
        int rd  = $urandom_range(7);
        int r1  = $urandom_range(7);
        int r2  = $urandom_range(7);
        int f3  = $urandom_range(7);
        int imm = $urandom;
        int off = ($urandom_range(15) - 8) * 4;
        int mf3 = ($urandom_range(3) == 0) ? $urandom_range(7) : 2;
        case (cls)
            0: return enc_u(imm, rd, 7'h37);
            1: return enc_u(imm, rd, 7'h17);
            2: return enc_j(off, rd);
            3: return enc_i($urandom_range(63), r1, 0, rd, 7'h67);
            4: return enc_b(off, r2, r1, f3);
            5: return enc_i(imm, r1, mf3, rd, 7'h03);
            6: return {imm[11:5], r2[4:0], r1[4:0], mf3[2:0], imm[4:0], 7'h23};
            7: return enc_i(imm, r1, f3, rd, 7'h13);
            8: return {1'b0, imm[0], 5'h0, r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic set_env(input int tp, input int sp, input int dmin, input int dmax, input int hold);
        take_pct = tp; same_pct = sp; dly_min = dmin; dly_max = dmax; hold_cfg = hold;
    endtask

    task automatic load_lui_program();
        clear_mem();
        mem[0] = enc_u(32'h12345, 2, 7'h37);
        mem[1] = enc_i(32'h678, 2, 0, 2, 7'h13);
        mem[2] = enc_s(32'h104, 2, 0);
        mem[3] = enc_i(32'h104, 0, 2, 3, 7'h03);
        mem[4] = enc_s(32'h108, 3, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1;
        EN_obtain_rq_get = 0;
        EN_send_rs_put   = 0;
        send_rs_put      = 0;
        set_env(100, 100, 0, 0, 0);

        // ADDI x1,x0,5 ; SW x1,0x100(x0)
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, 7'h13);
        mem[1] = enc_s(32'h100, 1, 0);
        do_reset();
        run(3);
        check("sw_addr", dut_wr_addr, 32'h100);
        check("sw_data", dut_wr_data, 32'h5);

        // LUI/ADDI/SW/LW/SW round trip through memory
        load_lui_program();
        do_reset();
        run(8);
        check("lw_sw_addr", dut_wr_addr, 32'h108);
        check("lw_sw_data", dut_wr_data, 32'h1234_5678);

        // BEQ taken then BNE not taken
        clear_mem();
        mem[0] = enc_b(8, 0, 0, 0);
        mem[2] = enc_b(8, 0, 0, 1);
        do_reset();
        run(3);
        check("beq_target", fetch_log[1], 32'h8);
        check("bne_fallthrough", fetch_log[2], 32'hc);

        // JAL x1,+8 at 0x10 ; SW x1,0x200(x0) at 0x18
        clear_mem();
        mem[4] = enc_j(8, 1);
        mem[6] = enc_s(32'h200, 1, 0);
        do_reset();
        run(7);
        check("jal_fetch", fetch_log[5], 32'h18);
        check("jal_link_addr", dut_wr_addr, 32'h200);
        check("jal_link_data", dut_wr_data, 32'h14);

        // Response delayed 5 cycles and every request withheld 5 cycles
        set_env(100, 0, 5, 5, 5);
        load_lui_program();
        do_reset();
        run(8);
        check("slow_env_data", dut_wr_data, 32'h1234_5678);

        // Random programs under a random environment; each new reset lands
        // mid-transaction of the previous run
        set_env(70, 50, 0, 4, 0);
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 1024; i++) mem[i] = rand_ins();
            do_reset();
            run(300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
